// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   DATA_BITS  : payload width of one 8N1 character
//   state_t    : arbiter FSM encoding
//   wrap_inc   : modulo-n increment used for the round-robin pointer
package uart_tx_arbiter_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_BUSY = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    int res;
    if (idx >= n - 1) begin
      res = 0;
    end else begin
      res = idx + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot of the chosen requester (zero when none)
//   idx   : binary index of the chosen requester
//   any   : at least one request present
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Scan from ptr upwards with wrap; first request found wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand + 0;
      end
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmitter among NUM_REQ byte producers.
//   clk, rst   : clock; asynchronous active-low reset
//   req_valid  : requester i has a byte ready
//   req_data   : byte of requester i at [8*i +: 8]
//   req_last   : byte ends requester i's frame (0 keeps the lock)
//   req_ready  : one-cycle acknowledge, byte i captured
//   tx_start   : one-cycle start pulse to the transmitter
//   tx_data    : byte to the transmitter, held until busy falls
//   tx_busy    : transmitter busy flag
//   grant_id   : index of the current or most recent owner
//   active     : arbiter owns the transmitter
//   err        : one-cycle pulse when tx_busy never rose after a start
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [DATA_BITS*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  output logic [IDW-1:0]                 grant_id,
  output logic                           active,
  output logic                           err
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t               state_r, state_nxt;
  logic                 lock_r, lock_nxt;
  logic [IDW-1:0]       ptr_r, ptr_nxt;
  logic [CW-1:0]        ctr_r, ctr_nxt;
  logic [NUM_REQ-1:0]   ready_r, ready_nxt;
  logic                 start_r, start_nxt;
  logic [DATA_BITS-1:0] data_r, data_nxt;
  logic [IDW-1:0]       gid_r, gid_nxt;
  logic                 err_r, err_nxt;
  logic                 active_r;

  logic [NUM_REQ-1:0]   req_masked;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;
  logic                 grant_now;

  // While a frame is locked only the owner is eligible.
  always_comb begin
    req_masked = req_valid;
    if (lock_r) begin
      req_masked = req_valid & (NUM_REQ'(1) << gid_r);
    end else begin
      req_masked = req_valid;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_masked),
    .ptr   (ptr_r),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_r;
    lock_nxt  = lock_r;
    ptr_nxt   = ptr_r;
    ctr_nxt   = ctr_r;
    ready_nxt = '0;
    start_nxt = 1'b0;
    data_nxt  = data_r;
    gid_nxt   = gid_r;
    err_nxt   = 1'b0;
    grant_now = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (!tx_busy && pick_any) begin
          grant_now = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
          ctr_nxt   = '0;
        end else if (ctr_r == CW'(BUSY_TIMEOUT)) begin
          // Transmitter never acknowledged: abandon the frame.
          err_nxt   = 1'b1;
          lock_nxt  = 1'b0;
          ptr_nxt   = IDW'(wrap_inc(int'(gid_r), NUM_REQ));
          ctr_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          ctr_nxt = ctr_r + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (lock_r) begin
          // Masked picker only sees the owner here.
          if (pick_any) begin
            grant_now = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          ptr_nxt   = IDW'(wrap_inc(int'(gid_r), NUM_REQ));
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (grant_now) begin
      ready_nxt = pick_grant;
      start_nxt = 1'b1;
      data_nxt  = req_data[int'(pick_idx) * DATA_BITS +: DATA_BITS];
      gid_nxt   = pick_idx;
      lock_nxt  = ~req_last[pick_idx];
      ctr_nxt   = '0;
      state_nxt = ST_WAIT_BUSY;
    end else begin
      start_nxt = start_nxt;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      lock_r   <= 1'b0;
      ptr_r    <= '0;
      ctr_r    <= '0;
      ready_r  <= '0;
      start_r  <= 1'b0;
      data_r   <= '0;
      gid_r    <= '0;
      err_r    <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      lock_r   <= lock_nxt;
      ptr_r    <= ptr_nxt;
      ctr_r    <= ctr_nxt;
      ready_r  <= ready_nxt;
      start_r  <= start_nxt;
      data_r   <= data_nxt;
      gid_r    <= gid_nxt;
      err_r    <= err_nxt;
      active_r <= (state_nxt != ST_IDLE);
    end
  end

  assign req_ready = ready_r;
  assign tx_start  = start_r;
  assign tx_data   = data_r;
  assign grant_id  = gid_r;
  assign active    = active_r;
  assign err       = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues drive the
// inputs, a small transmitter model drives tx_busy, and a scoreboard of
// expected {grant_id, byte} pairs is checked at every tx_start.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int IDW          = 2;
  localparam int FRAME        = 6;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_busy;
  logic [IDW-1:0]         grant_id;
  logic                   active;
  logic                   err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .err       (err)
  );

  logic [8:0]  rq [NUM_REQ][$];   // {last, data} per requester
  logic [15:0] sb [$];            // expected {grant_id, data}
  int n_cmp, n_bad;
  int cyc, start_cyc, fall_cyc, gap_valid, gap_fall, err_cnt, busy_cnt;
  int drive_cyc [NUM_REQ];
  bit never_busy, force_busy, rst_seen;
  logic [7:0] last_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #2;
      done = (sb.size() == 0) && all_empty() && !tx_busy && !active;
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requester drivers, output monitor and transmitter model.
  initial begin
    logic [15:0] e;
    bit started, nb;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    busy_cnt = 0; fall_cyc = 0; start_cyc = 0; last_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) drive_cyc[i] = 0;
    forever begin
      @(negedge clk);
      started = 1'b0;
      if (!rst_n) rst_seen = 1'b1;
      if (rst_n) begin
        if (req_ready != '0) begin
          check("ready_onehot", 32'($countones(req_ready)), 32'd1);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
              if (rq[i].size() > 0) void'(rq[i].pop_front());
              else check("ready_no_data", 32'(rq[i].size()), 32'd1);
            end
          end
        end
        if (tx_start) begin
          if (sb.size() == 0) begin
            check("start_unexpected", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[7:0]));
            check("grant_id", 32'(grant_id), 32'(e[15:8]));
            check("req_ready", 32'(req_ready), 32'd1 << e[15:8]);
          end
          gap_valid = cyc - drive_cyc[grant_id];
          gap_fall  = cyc - fall_cyc;
          start_cyc = cyc;
          last_byte = tx_data;
          rst_seen  = 1'b0;
          started   = 1'b1;
        end
        if (err) begin
          err_cnt++;
          check("err_latency", 32'(cyc - start_cyc), 32'(BUSY_TIMEOUT + 1));
          check("err_active", 32'(active), 32'd0);
        end
      end
      if (started && !never_busy) begin
        busy_cnt = FRAME;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0 && !rst_seen) check("data_hold", 32'(tx_data), 32'(last_byte));
      end
      nb = force_busy || (busy_cnt > 0);
      if (tx_busy && !nb) fall_cyc = cyc;
      tx_busy = nb;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0) begin
          if (!req_valid[i]) drive_cyc[i] = cyc;
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]       = rq[i][0][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  initial begin
    bit hit;
    n_cmp = 0; n_bad = 0; err_cnt = 0;
    never_busy = 1'b0; force_busy = 1'b0; rst_seen = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single byte from requester 0
    @(negedge clk); #2;
    rq[0].push_back({1'b1, 8'hA5}); sb.push_back({8'd0, 8'hA5});
    wait_idle("t1", 60);
    check("t1_latency", 32'(gap_valid), 32'd1);
    check("t1_idle", 32'(active), 32'd0);

    // fresh pointer for the rotation test
    @(negedge clk); #2; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b1;

    // 2: all four at once, then a lone req0 after the pointer wraps
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].push_back({1'b1, 8'h10 + 8'(i)});
      sb.push_back({8'(i), 8'h10 + 8'(i)});
    end
    wait_idle("t2", 200);
    rq[0].push_back({1'b1, 8'h20}); sb.push_back({8'd0, 8'h20});
    wait_idle("t2b", 60);

    // 3: locked three-byte frame from req1 while req2 waits
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b0, 8'h22});
    rq[1].push_back({1'b1, 8'h33});
    rq[2].push_back({1'b1, 8'h2C});
    sb.push_back({8'd1, 8'h11}); sb.push_back({8'd1, 8'h22});
    sb.push_back({8'd1, 8'h33}); sb.push_back({8'd2, 8'h2C});
    wait_idle("t3", 200);

    // 4: transmitter never answers a lock-opening byte from req3
    never_busy = 1'b1;
    rq[3].push_back({1'b0, 8'h4A}); sb.push_back({8'd3, 8'h4A});
    for (int k = 0; k < 100 && err_cnt == 0; k++) begin
      @(negedge clk); #2;
    end
    check("t4_err_seen", 32'(err_cnt), 32'd1);
    never_busy = 1'b0;
    rq[0].push_back({1'b1, 8'h4C}); rq[3].push_back({1'b1, 8'h4B});
    sb.push_back({8'd0, 8'h4C}); sb.push_back({8'd3, 8'h4B});
    wait_idle("t4", 120);

    // 5: reset while the transmitter is busy
    rq[1].push_back({1'b1, 8'h5A}); sb.push_back({8'd1, 8'h5A});
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk); #2;
      hit = (sb.size() == 0) && tx_busy && active;
    end
    @(negedge clk); #2;
    check("t5_active", 32'(active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_ready", 32'(req_ready), 32'd0);
    check("t5_start", 32'(tx_start), 32'd0);
    check("t5_data", 32'(tx_data), 32'd0);
    check("t5_gid", 32'(grant_id), 32'd0);
    check("t5_active0", 32'(active), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b1;
    rq[3].push_back({1'b1, 8'h5C}); sb.push_back({8'd3, 8'h5C});
    wait_idle("t5", 80);

    // 6: busy held high in IDLE blocks the grant
    force_busy = 1'b1;
    @(negedge clk); #2;
    rq[0].push_back({1'b1, 8'h66}); sb.push_back({8'd0, 8'h66});
    repeat (10) @(negedge clk);
    #2;
    check("t6_no_grant", 32'(rq[0].size()), 32'd1);
    check("t6_sb_pending", 32'(sb.size()), 32'd1);
    force_busy = 1'b0;
    wait_idle("t6", 60);
    check("t6_release_lat", 32'(gap_fall), 32'd1);

    check("err_total", 32'(err_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
